// File: rtl/word_divider_pkg.sv
// rtl/word_divider_pkg.sv - shared word width and divider FSM encoding
package word_divider_pkg;

    localparam int WORD_W = 16;
    localparam logic [3:0] LAST_ITER = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/word_CLA.sv
// rtl/word_CLA.sv - 16-bit two-level carry-lookahead adder (four 4-bit groups)
module word_CLA
    import word_divider_pkg::*;
(
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic              CIn,
    output logic [WORD_W-1:0] Sum,
    output logic              COut
);

    logic [WORD_W-1:0] w_g;
    logic [WORD_W-1:0] w_p;
    logic [3:0]        w_gg;
    logic [3:0]        w_pg;
    logic [4:0]        w_cg;

    assign w_g = A & B;
    assign w_p = A ^ B;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_grp
            logic [3:0] w_g4;
            logic [3:0] w_p4;
            logic [3:0] w_c4;

            assign w_g4 = w_g[4*k +: 4];
            assign w_p4 = w_p[4*k +: 4];

            assign w_gg[k] = w_g4[3] | (w_p4[3] & w_g4[2]) | (w_p4[3] & w_p4[2] & w_g4[1])
                           | (w_p4[3] & w_p4[2] & w_p4[1] & w_g4[0]);
            assign w_pg[k] = &w_p4;

            // In-group carries expanded from the group carry-in only
            assign w_c4[0] = w_cg[k];
            assign w_c4[1] = w_g4[0] | (w_p4[0] & w_cg[k]);
            assign w_c4[2] = w_g4[1] | (w_p4[1] & w_g4[0]) | (w_p4[1] & w_p4[0] & w_cg[k]);
            assign w_c4[3] = w_g4[2] | (w_p4[2] & w_g4[1]) | (w_p4[2] & w_p4[1] & w_g4[0])
                           | (w_p4[2] & w_p4[1] & w_p4[0] & w_cg[k]);

            assign Sum[4*k +: 4] = w_p4 ^ w_c4;
        end
    endgenerate

    assign w_cg[0] = CIn;
    assign w_cg[1] = w_gg[0] | (w_pg[0] & CIn);
    assign w_cg[2] = w_gg[1] | (w_pg[1] & w_gg[0]) | (w_pg[1] & w_pg[0] & CIn);
    assign w_cg[3] = w_gg[2] | (w_pg[2] & w_gg[1]) | (w_pg[2] & w_pg[1] & w_gg[0])
                   | (w_pg[2] & w_pg[1] & w_pg[0] & CIn);
    assign w_cg[4] = w_gg[3] | (w_pg[3] & w_gg[2]) | (w_pg[3] & w_pg[2] & w_gg[1])
                   | (w_pg[3] & w_pg[2] & w_pg[1] & w_gg[0])
                   | (w_pg[3] & w_pg[2] & w_pg[1] & w_pg[0] & CIn);

    assign COut = w_cg[4];

endmodule

// File: rtl/word_divider.sv
// rtl/word_divider.sv - 16-bit unsigned restoring divider, one quotient bit per cycle
module word_divider
    import word_divider_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] Dividend,
    input  logic [WORD_W-1:0] Divisor,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] Quotient,
    output logic [WORD_W-1:0] Remainder,
    output logic              DivByZero
);

    div_state_t        r_state;
    div_state_t        w_state_nxt;
    logic [3:0]        r_cnt;
    logic [WORD_W-1:0] r_quo;
    logic [WORD_W-1:0] r_rem;
    logic [WORD_W-1:0] r_divisor;
    logic [WORD_W-1:0] r_quotient;
    logic [WORD_W-1:0] r_remainder;
    logic              r_dbz;

    logic              w_accept;
    logic [WORD_W-1:0] w_rem_sh;
    logic [WORD_W-1:0] w_trial;
    logic              w_cout;
    logic              w_borrow;
    logic [WORD_W-1:0] w_rem_nxt;
    logic [WORD_W-1:0] w_quo_nxt;

    // Next dividend bit enters the partial remainder from the quotient register's MSB
    assign w_rem_sh = {r_rem[WORD_W-2:0], r_quo[WORD_W-1]};

    word_CLA u_trial (
        .A    (w_rem_sh),
        .B    (~r_divisor),
        .CIn  (1'b1),
        .Sum  (w_trial),
        .COut (w_cout)
    );

    assign w_borrow  = ~w_cout;
    assign w_rem_nxt = w_borrow ? w_rem_sh : w_trial;
    assign w_quo_nxt = {r_quo[WORD_W-2:0], ~w_borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (Divisor == '0) ? ST_DONE : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == LAST_ITER) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_quo     <= Dividend;
            r_rem     <= '0;
            r_divisor <= Divisor;
            if (Divisor == '0) begin
                r_quotient  <= '1;
                r_remainder <= Dividend;
                r_dbz       <= 1'b1;
            end else begin
                r_dbz <= 1'b0;
            end
        end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt + 4'd1;
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            // Results are published only on the final iteration so they hold through the next run
            if (r_cnt == LAST_ITER) begin
                r_quotient  <= w_quo_nxt;
                r_remainder <= w_rem_nxt;
            end
        end
    end

    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign Quotient  = r_quotient;
    assign Remainder = r_remainder;
    assign DivByZero = r_dbz;

endmodule

// File: tb/tb_word_divider.sv
// tb/tb_word_divider.sv - directed self-checking bench for word_divider
module tb_word_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] Dividend;
    logic [15:0] Divisor;
    logic        busy;
    logic        done;
    logic [15:0] Quotient;
    logic [15:0] Remainder;
    logic        DivByZero;

    int tests = 0;
    int fails = 0;

    word_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .busy      (busy),
        .done      (done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts edges since the accept edge until done is seen, bounded
    task automatic wait_done(input int lat_in, output int lat, output int bcnt);
        lat  = lat_in;
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eq, input logic [15:0] er, input logic ez,
                           input int elat);
        int lat;
        int bcnt;
        @(negedge clk);
        Dividend = a;
        Divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1, lat, bcnt);
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_busy_cycles"}, bcnt, elat - 1);
        chk({tag, "_quotient"}, Quotient, eq);
        chk({tag, "_remainder"}, Remainder, er);
        chk({tag, "_divbyzero"}, DivByZero, ez);
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, done, 1'b0);
        chk({tag, "_quotient_hold"}, Quotient, eq);
    endtask

    initial begin
        int lat;
        int bcnt;
        int seen;

        rst_n    = 1'b1;
        start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        #3 rst_n = 1'b0;
        #20;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_quotient", Quotient, 16'h0);
        chk("reset_remainder", Remainder, 16'h0);
        chk("reset_divbyzero", DivByZero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
        run_div("dffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17);
        run_div("d3_10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17);
        run_div("d5_0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1);
        run_div("d8_2", 16'd8, 16'd2, 16'd4, 16'd0, 1'b0, 17);
        run_div("d1000_3", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 17);

        // Start during RUN must be ignored
        @(negedge clk);
        Dividend = 16'd50;
        Divisor  = 16'd5;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        Dividend = 16'd9;
        Divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(6, lat, bcnt);
        chk("ignore_latency", lat, 17);
        chk("ignore_quotient", Quotient, 16'd10);
        chk("ignore_remainder", Remainder, 16'd0);

        // Reset at cycle 8 of RUN aborts; next start is taken on the first edge after release
        @(negedge clk);
        Dividend = 16'd1000;
        Divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        chk("pre_abort_busy", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_quotient", Quotient, 16'h0);
        chk("abort_remainder", Remainder, 16'h0);
        chk("abort_divbyzero", DivByZero, 1'b0);
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_div("d7_2_after_reset", 16'd7, 16'd2, 16'd3, 16'd1, 1'b0, 17);

        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        chk("no_done_after_reset", seen, 0);

        // start held high through DONE chains a second division
        @(negedge clk);
        Dividend = 16'd10;
        Divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        wait_done(1, lat, bcnt);
        chk("b2b_first_latency", lat, 17);
        chk("b2b_first_quotient", Quotient, 16'd3);
        chk("b2b_first_remainder", Remainder, 16'd1);
        Dividend = 16'd20;
        Divisor  = 16'd6;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_reaccept_busy", busy, 1'b1);
        wait_done(1, lat, bcnt);
        chk("b2b_second_latency", lat, 17);
        chk("b2b_second_quotient", Quotient, 16'd3);
        chk("b2b_second_remainder", Remainder, 16'd2);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/word_divider.md
WORD_DIVIDER -- requirements
Module: word_divider

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 16 bits, matching the CPU word.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 start  input  1  request to begin a division; sampled on rising clk.
REQ-005 Dividend  input  16  unsigned dividend; sampled only on the edge that accepts start.
REQ-006 Divisor  input  16  unsigned divisor; sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse; Quotient/Remainder/DivByZero valid.
REQ-009 Quotient  output  16  unsigned quotient.
REQ-010 Remainder  output  16  unsigned remainder.
REQ-011 DivByZero  output  1  high with done when Divisor was zero.

Function
REQ-012 Algorithm SHALL be unsigned restoring division, one quotient bit per cycle, MSB first.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; the reset state SHALL be IDLE.
REQ-014 IDLE or DONE with start=1 at an edge: capture operands, clear the partial remainder, and clear the 4-bit iteration counter; go to RUN (Divisor!=0) or DONE (Divisor==0).
REQ-015 Each RUN edge: shift {rem,quo} left 1 with the next dividend bit; trial = rem - Divisor. If no borrow, rem = trial and quo bit = 1; else rem is kept and quo bit = 0.
REQ-016 RUN SHALL last exactly 16 edges; on the edge where counter==15, go to DONE.
REQ-017 Latency: with start accepted at edge t, done SHALL be high in the cycle after edge t+16 (17 edges total); divide-by-zero: done high after edge t+1.
REQ-018 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); DONE SHALL last exactly one cycle unless it is re-entered.
REQ-019 DONE with start=0 SHALL go to IDLE; Quotient/Remainder/DivByZero SHALL hold their values until the next accepted start.
REQ-020 start while in RUN SHALL be ignored; operands and progress SHALL be unaffected.
REQ-021 Divisor==0: Quotient=16'hFFFF, Remainder=Dividend, DivByZero=1.
REQ-022 DivByZero SHALL clear to 0 on any accepted start with a nonzero Divisor.
REQ-023 Dividend < Divisor: Quotient=0, Remainder=Dividend; Divisor==1: Quotient=Dividend, Remainder=0.
REQ-024 The trial subtraction SHALL be 16-bit: borrow = NOT carry-out of Remainder + ~Divisor + 1.

Reset
REQ-025 rst_n low SHALL asynchronously force state=IDLE, counter=0, busy=0, done=0, Quotient=0, Remainder=0, DivByZero=0.
REQ-026 Reset during RUN SHALL abort the division; no done pulse SHALL follow the release of reset.
REQ-027 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-028 The FSM state encoding and the width constant (16) SHALL be defined in the shared CPU package.
REQ-029 The trial subtraction SHALL use one instance of the existing word_CLA with B=~Divisor and CIn=1. borrow = ~COut.
REQ-030 No other sub-modules; the FSM and the shift registers SHALL be in word_divider.

Verification
REQ-031 Dividend=100, Divisor=7, start at edge t -> busy high for 16 cycles; done at t+17; Quotient=14, Remainder=2, DivByZero=0.
REQ-032 Dividend=16'hFFFF, Divisor=1 -> Quotient=16'hFFFF, Remainder=0; Dividend=3, Divisor=10 -> Quotient=0, Remainder=3.
REQ-033 Dividend=5, Divisor=0 -> done one cycle after start; Quotient=16'hFFFF, Remainder=5, DivByZero=1; a following 8/2 clears DivByZero and gives Quotient=4.
REQ-034 Start 50/5, then pulse start with 9/3 at cycle 5 of RUN -> second request ignored; result Quotient=10, Remainder=0.
REQ-035 rst_n low at cycle 8 of RUN -> all outputs 0 immediately; no done pulse; a new 7/2 run then gives Quotient=3, Remainder=1.
REQ-036 start held high across DONE -> back-to-back division accepted; second done 17 edges after the first.
